// File: rtl/avalon_buf_slave.sv
// Avalon-MM slave over a DEPTH x 256-bit register buffer: zero-fills after reset, then serves
// reads with a fixed READ_LATENCY return pipeline. Define AVS_STALL_EN for LFSR-driven waitrequest.
module avalon_buf_slave #(
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  avs_address,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [255:0] avs_writedata,
  output logic         avs_waitrequest,
  output logic [255:0] avs_readdata,
  output logic         avs_readdatavalid,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic         err_sticky
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PIPE_N = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        init_idx_q, init_idx_d;
  logic [255:0]            mem_q [DEPTH];
  logic [255:0]            mem_d [DEPTH];
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [255:0]            pipe_q [PIPE_N];
  logic [255:0]            pipe_d [PIPE_N];
  logic [255:0]            rdata_q, rdata_d;
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic                    err_q, err_d;

  logic                    stall;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    both_acc;
  logic [IDX_W-1:0]        addr_idx;
  logic                    unused_addr;

  assign addr_idx    = avs_address[5+IDX_W-1:5];
  assign unused_addr = ^{avs_address[31:5+IDX_W], avs_address[4:0]};

`ifdef AVS_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, frozen while the buffer is still being cleared
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_READY) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign avs_waitrequest = (state_q == ST_INIT) | stall;

  // A simultaneous read+write performs the write and drops the read.
  assign wr_acc   = avs_write & ~avs_waitrequest;
  assign rd_acc   = avs_read & ~avs_write & ~avs_waitrequest;
  assign both_acc = avs_read & avs_write & ~avs_waitrequest;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d    = ST_READY;
        init_idx_d = '0;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_INIT) begin
      mem_d[init_idx_q] = '0;
    end else if (wr_acc) begin
      mem_d[addr_idx] = avs_writedata;
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    if (rd_acc) rd_count_d = rd_count_q + 16'd1;
    if (wr_acc) wr_count_d = wr_count_q + 16'd1;
    if (both_acc) err_d = 1'b1;
  end

  assign vld_d = READ_LATENCY'({vld_q, rd_acc});

  // Data advances only alongside a valid token, so the output stage keeps the last returned word.
  if (READ_LATENCY == 1) begin : g_lat1
    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) rdata_d = mem_q[addr_idx];
    end
    assign pipe_d = pipe_q;
  end else begin : g_latn
    always_comb begin
      pipe_d  = pipe_q;
      rdata_d = rdata_q;
      if (rd_acc) pipe_d[0] = mem_q[addr_idx];
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        if (vld_q[i-1]) pipe_d[i] = pipe_q[i-1];
      end
      if (vld_q[READ_LATENCY-2]) rdata_d = pipe_q[READ_LATENCY-2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      vld_q      <= '0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      vld_q      <= vld_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    pipe_q <= pipe_d;
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = vld_q[READ_LATENCY-1];
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_avalon_buf_slave.sv
// Directed bench for avalon_buf_slave (DEPTH=16, READ_LATENCY=2); the AVS_STALL_EN build runs
// the LFSR stall sequence instead of the cycle-exact scenarios.
module tb_avalon_buf_slave;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [255:0] avs_writedata;
  logic         avs_waitrequest;
  logic [255:0] avs_readdata;
  logic         avs_readdatavalid;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic         err_sticky;

  int checks = 0;
  int errors = 0;

  avalon_buf_slave #(.DEPTH(16), .READ_LATENCY(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .rd_count          (rd_count),
    .wr_count          (wr_count),
    .err_sticky        (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 64) begin
      ok = !avs_waitrequest;
      tick();
      n++;
    end
    if (!ok) chk({tag, "_accept_timeout"}, 256'd0, 256'd1);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [255:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    wait_accept("wr");
    avs_write = 1'b0;
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input logic [255:0] exp);
    int k;
    avs_address = a;
    avs_read    = 1'b1;
    wait_accept(tag);
    avs_read = 1'b0;
    k = 1;
    while (!avs_readdatavalid && k < 8) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 256'(k), 256'(LAT));
    chk({tag, "_data"}, avs_readdata, exp);
    tick();
    chk({tag, "_single"}, 256'(avs_readdatavalid), 256'd0);
  endtask

  task automatic reset_and_init();
    int n = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    while (avs_waitrequest && n < 100) begin
      n++;
      tick();
    end
    chk("init_cycles", 256'(n), 256'd16);
  endtask

  initial begin
    logic [255:0] pat;
    logic [7:0]   m;
    int           acc;
    bit           seen;

    reset         = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_wait", 256'(avs_waitrequest), 256'd1);
    chk("rst_vld", 256'(avs_readdatavalid), 256'd0);
    chk("rst_rdata", avs_readdata, 256'd0);
    chk("rst_rdcnt", 256'(rd_count), 256'd0);
    chk("rst_wrcnt", 256'(wr_count), 256'd0);
    chk("rst_err", 256'(err_sticky), 256'd0);

`ifdef AVS_STALL_EN
    // Read held through INIT: must stall, then go through only on LFSR bit0=0 cycles.
    avs_address = 32'h40;
    avs_read    = 1'b1;
    reset       = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("init_wait", 256'(avs_waitrequest), 256'd1);
      tick();
    end
    chk("init_rdcnt", 256'(rd_count), 256'd0);
    m   = 8'hA5;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      chk("lfsr_wait", 256'(avs_waitrequest), 256'(m[0]));
      if (!m[0]) acc++;
      tick();
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
    avs_read = 1'b0;
    chk("stall_rdcnt", 256'(rd_count), 256'(acc));
    chk("stall_err", 256'(err_sticky), 256'd0);
`else
    // Release: 16 clearing cycles, then a read of a cleared word.
    reset = 1'b1;
    begin
      int n = 0;
      while (avs_waitrequest && n < 100) begin
        n++;
        tick();
      end
      chk("init_cycles", 256'(n), 256'd16);
    end
    do_rd("rd40", 32'h40, 256'd0);

    // Write then read the next cycle.
    reset_and_init();
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
    do_wr(32'h20, pat);
    do_rd("raw", 32'h20, pat);
    chk("raw_wrcnt", 256'(wr_count), 256'd1);
    chk("raw_rdcnt", 256'(rd_count), 256'd1);

    // Back-to-back reads return in order on consecutive cycles.
    do_wr(32'h00, 256'd1);
    do_wr(32'h20, 256'd2);
    do_wr(32'h40, 256'd3);
    avs_read    = 1'b1;
    avs_address = 32'h00;
    tick();
    chk("b2b_v0", 256'(avs_readdatavalid), 256'd0);
    avs_address = 32'h20;
    tick();
    chk("b2b_v1", 256'(avs_readdatavalid), 256'd1);
    chk("b2b_d1", avs_readdata, 256'd1);
    avs_address = 32'h40;
    tick();
    chk("b2b_v2", 256'(avs_readdatavalid), 256'd1);
    chk("b2b_d2", avs_readdata, 256'd2);
    avs_read = 1'b0;
    tick();
    chk("b2b_v3", 256'(avs_readdatavalid), 256'd1);
    chk("b2b_d3", avs_readdata, 256'd3);
    tick();
    chk("b2b_v4", 256'(avs_readdatavalid), 256'd0);
    chk("b2b_hold", avs_readdata, 256'd3);

    // Address wrap and ignored low bits.
    do_wr(32'h200, 256'hAA);
    do_rd("wrap", 32'h000, 256'hAA);
    do_rd("lowbits", 32'h01F, 256'hAA);
    chk("pre_err", 256'(err_sticky), 256'd0);

    // Read+write together: write lands, read dropped, error latched.
    avs_address   = 32'h20;
    avs_writedata = 256'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (avs_readdatavalid) seen = 1'b1;
      tick();
    end
    chk("rw_noresp", 256'(seen), 256'd0);
    chk("rw_err", 256'(err_sticky), 256'd1);
    chk("rw_rdcnt", 256'(rd_count), 256'd6);
    chk("rw_wrcnt", 256'(wr_count), 256'd6);
    do_rd("rw_word", 32'h20, 256'h55);
    chk("err_hold", 256'(err_sticky), 256'd1);

    // Reset with two reads in flight.
    avs_read    = 1'b1;
    avs_address = 32'h00;
    tick();
    avs_address = 32'h20;
    tick();
    avs_read = 1'b0;
    reset    = 1'b0;
    #1;
    chk("ar_vld", 256'(avs_readdatavalid), 256'd0);
    chk("ar_rdata", avs_readdata, 256'd0);
    chk("ar_rdcnt", 256'(rd_count), 256'd0);
    chk("ar_wrcnt", 256'(wr_count), 256'd0);
    chk("ar_err", 256'(err_sticky), 256'd0);
    chk("ar_wait", 256'(avs_waitrequest), 256'd1);
    tick();
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (avs_readdatavalid) seen = 1'b1;
      tick();
    end
    chk("ar_noresp", 256'(seen), 256'd0);
    do_rd("ar_cleared", 32'h20, 256'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_buf_slave.md
AVALON_BUF_SLAVE -- requirements
Module: avalon_buf_slave

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 16, number of 256-bit words; power of 2, 2..64.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; 1..4.

REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset. Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-low reset.
- avs_address, in, 32, byte address.
- avs_read, in, 1, read request.
- avs_write, in, 1, write request.
- avs_writedata, in, 256, write data.
- avs_waitrequest, out, 1, command stall.
- avs_readdata, out, 256, read return data.
- avs_readdatavalid, out, 1, avs_readdata is valid this cycle.
- rd_count, out, 16, count of accepted reads.
- wr_count, out, 16, count of accepted writes.
- err_sticky, out, 1, protocol error seen.

Function
REQ-003 The block SHALL implement an FSM with states:
- INIT: entered from reset; clears one word per cycle, index 0..DEPTH-1; moves to READY after word DEPTH-1 is cleared.
- READY: serves commands.

REQ-004 avs_waitrequest SHALL be 1 in INIT and 0 in READY, except as modified by REQ-016.

REQ-005 A command SHALL be accepted in any cycle where (avs_read or avs_write) is 1 and avs_waitrequest is 0; it is not accepted in any other cycle.

REQ-006 Word index SHALL be avs_address[5+log2(DEPTH)-1:5].
- avs_address[4:0] is ignored.
- Higher address bits are ignored, so addresses wrap modulo DEPTH*32.

REQ-007 An accepted write SHALL update the addressed word at the same clock edge.

REQ-008 An accepted read SHALL capture the addressed word at the acceptance edge. Consequences:
- A read accepted in the cycle after a write to the same word returns the new data.
- Write data arriving later does not alter a read already accepted.

REQ-009 Read response timing and ordering:
- Each accepted read SHALL produce exactly one cycle of avs_readdatavalid=1, exactly READ_LATENCY cycles after acceptance.
- Responses SHALL return in acceptance order.
- The pipeline SHALL sustain one accepted read per cycle; there is no response backpressure.

REQ-010 When avs_readdatavalid is 0, avs_readdata SHALL hold its last valid value.

REQ-011 If avs_read and avs_write are both 1 in an accepting cycle:
- the write SHALL be performed;
- the read SHALL be discarded, with no response;
- err_sticky SHALL be set.

REQ-012 Counters:
- rd_count SHALL increment by 1 per accepted, non-discarded read.
- wr_count SHALL increment by 1 per accepted write.
- Both wrap from 0xFFFF to 0x0000.

REQ-013 err_sticky SHALL clear only on reset.

REQ-014 Commands presented during INIT SHALL be stalled, not dropped. The master holds the command until it is accepted.

Reset
REQ-015 On reset assertion, regardless of state or in-flight reads, the block SHALL immediately take these values:
- State: INIT, init index 0.
- Outputs: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, rd_count=0, wr_count=0, err_sticky=0.
- All in-flight read responses are discarded.
- Memory is re-cleared by INIT after release.

Configuration
REQ-016 Macro AVS_STALL_EN SHALL select the stall behaviour in READY.
- Defined:
  - an 8-bit LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 0xA5 at reset) advances every READY cycle;
  - avs_waitrequest=1 in READY whenever LFSR bit 0 is 1;
  - the LFSR does not advance in INIT.
- Not defined: no LFSR exists, and avs_waitrequest is 0 throughout READY.

Verification
REQ-017 The bench SHALL cover these directed scenarios (AVS_STALL_EN undefined unless stated; stimulus -> required response):
- Reset release -> avs_waitrequest=1 for exactly 16 cycles, then 0; a read of address 0x40 returns 256'h0 exactly 2 cycles after acceptance.
- Write 0x1F..00 pattern to 0x20, read 0x20 the next cycle -> readdatavalid 2 cycles later with that pattern; wr_count=1, rd_count=1.
- Back-to-back reads of 0x00, 0x20, 0x40 (each previously written 1, 2, 3) -> readdatavalid high 3 consecutive cycles returning 1, 2, 3 in order.
- Write 0xAA to address 0x200 (DEPTH=16) -> reading 0x000 returns 0xAA (wrap).
- avs_read=avs_write=1 at address 0x20 with data 0x55 -> no response, word 1 = 0x55, err_sticky=1, rd_count unchanged.
- Reset asserted with 2 reads in flight -> no readdatavalid after reset; with AVS_STALL_EN defined, waitrequest follows the LFSR seeded 0xA5, and held commands are accepted only on LFSR bit0=0 cycles.
